// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between requesters and one rr_arbiter_lock.
//   i_request     [NUMBER_PORTS] per-port level request, bit i = port i
//   i_release     granted port's last transfer cycle (tail)
//   o_grant       [NUMBER_PORTS] registered one-hot grant, zero when idle
//   o_chosen      [CW] binary index of the granted port, zero when idle
//   o_grant_valid high while a grant is active
// The tail strobe is i_release because release is a reserved word.
interface rr_arbiter_lock_if #(
  parameter int unsigned NUMBER_PORTS = 4
);
  localparam int unsigned CW = $clog2(NUMBER_PORTS);

  logic [NUMBER_PORTS-1:0] i_request;
  logic                    i_release;
  logic [NUMBER_PORTS-1:0] o_grant;
  logic [CW-1:0]           o_chosen;
  logic                    o_grant_valid;

  modport master (
    output i_request, i_release,
    input  o_grant, o_chosen, o_grant_valid
  );

  modport slave (
    input  i_request, i_release,
    output o_grant, o_chosen, o_grant_valid
  );
endinterface

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with optional grant lock, one per router output port.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      rr_arbiter_lock_if.slave: i_request, i_release in;
//            o_grant, o_chosen, o_grant_valid out (all registered)
// Parameters:
//   number_ports  requesters, 2..32 (non-power-of-2 allowed)
//   lock_mode     1: hold grant until release or request drop
//                 0: re-arbitrate every cycle
module rr_arbiter_lock #(
  parameter int unsigned number_ports = 4,
  parameter int unsigned lock_mode    = 1
) (
  input logic               clk,
  input logic               reset_n,
  rr_arbiter_lock_if.slave  bus
);

  localparam int unsigned N  = number_ports;
  localparam int unsigned CW = $clog2(number_ports);
  localparam logic [CW:0]   NP   = (CW+1)'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [CW-1:0]   r_chosen, w_chosen_nxt;
  logic [CW-1:0]   r_ptr, w_ptr_nxt;

  logic [CW-1:0]   w_chosen_inc;
  logic            w_end;
  logic [CW-1:0]   w_base;
  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic            w_found;
  logic [CW-1:0]   w_off;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_win;
  logic [CW-1:0]   w_win_inc;
  logic [N-1:0]    w_win_oh;

  // Winner search: rotate request so the base port sits at bit 0, take the
  // lowest set bit, then map the offset back to a port index mod N.
  always_comb begin
    w_chosen_inc = (r_chosen == LAST) ? '0 : r_chosen + 1'b1;
    w_end        = bus.i_release | ~bus.i_request[r_chosen];

    // When a locked grant ends, the pointer update and the new search happen
    // on the same edge, so search from chosen+1 directly for zero bubble.
    if (lock_mode != 0 && r_state == BUSY)
      w_base = w_chosen_inc;
    else
      w_base = r_ptr;

    w_dbl = {bus.i_request, bus.i_request};
    w_rot = '0;
    for (int unsigned i = 0; i < N; i++)
      w_rot[i] = w_dbl[i + 32'(w_base)];

    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = CW'(i);
      end
    end

    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= NP)
      w_win = CW'(w_sum - NP);
    else
      w_win = w_sum[CW-1:0];

    w_win_inc = (w_win == LAST) ? '0 : w_win + 1'b1;

    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // Next-state / next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_chosen_nxt = r_chosen;
    w_ptr_nxt    = r_ptr;

    if (lock_mode == 0) begin
      // Free-running: every edge re-arbitrates, pointer follows each winner.
      if (w_found) begin
        w_state_nxt  = BUSY;
        w_grant_nxt  = w_win_oh;
        w_chosen_nxt = w_win;
        w_ptr_nxt    = w_win_inc;
      end else begin
        w_state_nxt  = IDLE;
        w_grant_nxt  = '0;
        w_chosen_nxt = '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_state_nxt  = BUSY;
            w_grant_nxt  = w_win_oh;
            w_chosen_nxt = w_win;
          end
        end
        BUSY: begin
          if (w_end) begin
            w_ptr_nxt = w_chosen_inc;
            if (w_found) begin
              w_grant_nxt  = w_win_oh;
              w_chosen_nxt = w_win;
            end else begin
              w_state_nxt  = IDLE;
              w_grant_nxt  = '0;
              w_chosen_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = '0;
          w_chosen_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_chosen <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_chosen <= w_chosen_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_chosen      = r_chosen;
  assign bus.o_grant_valid = (r_state == BUSY);

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed bench for rr_arbiter_lock: a 4-port locked arbiter, a 4-port
// free-running arbiter and a 3-port free-running arbiter share clock/reset.
module tb_rr_arbiter_lock;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_lock_if #(.NUMBER_PORTS(4)) bus_lk ();
  rr_arbiter_lock_if #(.NUMBER_PORTS(4)) bus_r4 ();
  rr_arbiter_lock_if #(.NUMBER_PORTS(3)) bus_r3 ();

  rr_arbiter_lock #(.number_ports(4), .lock_mode(1)) u_lk (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_lk.slave)
  );

  rr_arbiter_lock #(.number_ports(4), .lock_mode(0)) u_r4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_r4.slave)
  );

  rr_arbiter_lock #(.number_ports(3), .lock_mode(0)) u_r3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_r3.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks grant, chosen and grant_valid against an expected (valid, index).
  task automatic exp_out(input string tag, input logic [31:0] g, input logic [31:0] c,
                         input logic v, input bit vexp, input int unsigned ch);
    check({tag, "_grant"},  g, vexp ? (32'd1 << ch) : 32'd0);
    check({tag, "_chosen"}, c, vexp ? ch : 32'd0);
    check({tag, "_valid"},  {31'd0, v}, {31'd0, vexp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input string tag, input bit vexp, input int unsigned ch);
    exp_out(tag, 32'(bus_lk.o_grant), 32'(bus_lk.o_chosen), bus_lk.o_grant_valid, vexp, ch);
  endtask

  task automatic r4(input string tag, input bit vexp, input int unsigned ch);
    exp_out(tag, 32'(bus_r4.o_grant), 32'(bus_r4.o_chosen), bus_r4.o_grant_valid, vexp, ch);
  endtask

  task automatic r3(input string tag, input bit vexp, input int unsigned ch);
    exp_out(tag, 32'(bus_r3.o_grant), 32'(bus_r3.o_chosen), bus_r3.o_grant_valid, vexp, ch);
  endtask

  initial begin
    bus_lk.i_request = '0; bus_lk.i_release = 1'b0;
    bus_r4.i_request = '0; bus_r4.i_release = 1'b0;
    bus_r3.i_request = '0; bus_r3.i_release = 1'b0;

    // Power-on reset
    #2 reset_n = 1'b0;
    #1;
    lk("rst_lk", 1'b0, 0);
    r4("rst_r4", 1'b0, 0);
    r3("rst_r3", 1'b0, 0);
    tick; tick;
    reset_n = 1'b1;

    // Lock hold: port 1 held three cycles while port 3 waits, release on 3rd
    bus_lk.i_request = 4'b0010;
    tick; lk("hold_c1", 1'b1, 1);
    bus_lk.i_request = 4'b1010;
    tick; lk("hold_c2", 1'b1, 1);
    tick; lk("hold_c3", 1'b1, 1);
    bus_lk.i_release = 1'b1;
    tick; lk("hold_next", 1'b1, 3);   // back-to-back, no bubble
    bus_lk.i_release = 1'b0;
    bus_lk.i_request = 4'b0000;
    tick; lk("hold_idle", 1'b0, 0);   // port 3 ended -> ptr wraps to 0

    // Wrap-around: grant port 2, release with 0101 pending -> ptr=3 -> port 0
    bus_lk.i_request = 4'b0100;
    tick; lk("wrap_g2", 1'b1, 2);
    bus_lk.i_request = 4'b0101;
    bus_lk.i_release = 1'b1;
    tick; lk("wrap_g0", 1'b1, 0);
    tick; lk("wrap_g2b", 1'b1, 2);    // release again: ptr=1 -> port 2

    // Abort: port 2 drops request without release -> ptr=3 -> port 0
    bus_lk.i_release = 1'b0;
    bus_lk.i_request = 4'b0001;
    tick; lk("abort_g0", 1'b1, 0);
    bus_lk.i_request = 4'b1001;
    bus_lk.i_release = 1'b1;
    tick; lk("abort_g3", 1'b1, 3);
    bus_lk.i_release = 1'b0;
    bus_lk.i_request = 4'b0000;
    tick; lk("abort_idle", 1'b0, 0);

    // Release while idle is ignored
    bus_lk.i_release = 1'b1;
    tick; lk("rel_idle", 1'b0, 0);
    bus_lk.i_release = 1'b0;

    // Release and request drop together advance ptr only once (ptr=0 here)
    bus_lk.i_request = 4'b0010;
    tick; lk("both_g1", 1'b1, 1);
    bus_lk.i_request = 4'b0101;
    bus_lk.i_release = 1'b1;
    tick; lk("both_g2", 1'b1, 2);     // ptr=2; a double advance would pick 0
    bus_lk.i_release = 1'b0;
    bus_lk.i_request = 4'b0000;
    tick; lk("both_idle", 1'b0, 0);

    // Asynchronous reset mid-grant
    bus_lk.i_request = 4'b0100;
    tick; lk("ar_g2", 1'b1, 2);
    #3 reset_n = 1'b0;
    #1 lk("ar_async", 1'b0, 0);
    tick;
    lk("ar_held", 1'b0, 0);
    reset_n = 1'b1;
    tick; lk("ar_restart", 1'b1, 2);
    bus_lk.i_request = 4'b0000;
    tick; lk("ar_idle", 1'b0, 0);

    // Free-running fairness, 4 ports and 3 ports, release ignored
    bus_r4.i_request = 4'b1111;
    bus_r4.i_release = 1'b1;
    bus_r3.i_request = 3'b111;
    tick; r4("rr4_s0", 1'b1, 0); r3("rr3_s0", 1'b1, 0);
    tick; r4("rr4_s1", 1'b1, 1); r3("rr3_s1", 1'b1, 1);
    tick; r4("rr4_s2", 1'b1, 2); r3("rr3_s2", 1'b1, 2);
    tick; r4("rr4_s3", 1'b1, 3); r3("rr3_s3", 1'b1, 0);
    tick; r4("rr4_s4", 1'b1, 0); r3("rr3_s4", 1'b1, 1);
    tick; r4("rr4_s5", 1'b1, 1); r3("rr3_s5", 1'b1, 2);
    bus_r4.i_request = 4'b0000;
    bus_r3.i_request = 3'b000;
    tick; r4("rr4_idle", 1'b0, 0); r3("rr3_idle", 1'b0, 0);

    // Idle keeps ptr (4p: 2, 3p: 0); sparse requests
    bus_r4.i_request = 4'b0011;
    bus_r3.i_request = 3'b110;
    tick; r4("rr4_sp0", 1'b1, 0); r3("rr3_sp0", 1'b1, 1);
    tick; r4("rr4_sp1", 1'b1, 1); r3("rr3_sp1", 1'b1, 2);
    tick; r4("rr4_sp2", 1'b1, 0); r3("rr3_sp2", 1'b1, 1);
    bus_r4.i_request = 4'b0000;
    bus_r3.i_request = 3'b000;
    tick; r4("rr4_end", 1'b0, 0); r3("rr3_end", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
